operand_fifo: RTL and testbench
===============================

# operand_fifo

Elastic circular-buffer FIFO for one dataflow channel, placed directly upstream of a two-operand arithmetic unit such as `andi`. Its output drives one operand channel (`lhs` or `rhs`) so an early-arriving operand can be stored while the join inside the arithmetic unit waits for the other operand. It uses the standard valid/ready handshake. There is no combinational path from any input to any output, so it also breaks valid, ready and data timing paths.

## Interface
- `DATA_TYPE`, 32: data width in bits; minimum 1.
- `NUM_SLOTS`, 4: storage depth; minimum 2; need not be a power of two.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ins`  in  DATA_TYPE: upstream data.
- `ins_valid`  in  1: upstream token present.
- `ins_ready`  out  1: FIFO accepts a token this cycle.
- `outs`  out  DATA_TYPE: head token, wired to the operand input of the arithmetic unit.
- `outs_valid`  out  1: head token present.
- `outs_ready`  in  1: downstream consumes the head this cycle.

## Operation
- **Storage**
  - `NUM_SLOTS` × `DATA_TYPE` register array.
  - Head pointer `hd` and tail pointer `tl`, each clog2(`NUM_SLOTS`) bits wide (minimum 1 bit).
  - Occupancy counter `cnt`, clog2(`NUM_SLOTS`+1) bits wide.
- **Handshake conditions**
  - push = `ins_valid` & `ins_ready`
  - pop = `outs_valid` & `outs_ready`
- **Push:** write `ins` into slot `tl`, then advance `tl`.
- **Pop:** advance `hd`.
- **Pointer wrap:** a pointer at `NUM_SLOTS`-1 advances to 0. Explicit compare-and-reset; modulo-by-width is not used, so non-power-of-two depths are supported.
- **Occupancy update:**
  - push only: `cnt` += 1
  - pop only: `cnt` -= 1
  - push and pop together: `cnt` unchanged; both pointers advance.
- **Output signals** (registered-state only):
  - `outs_valid` = (`cnt` != 0)
  - `ins_ready` = (`cnt` != `NUM_SLOTS`)
  - `outs` = slot[`hd`], driven directly from the array.
- **Empty (`cnt`=0):** `outs_valid`=0. The value on `outs` is don't-care. There is no bypass, so a pushed token is never visible in the cycle it is pushed.
- **Full (`cnt`=`NUM_SLOTS`):** `ins_ready`=0 even if `outs_ready`=1. A pop and a push in the same cycle at full is therefore impossible by construction. This deliberately costs one cycle of throughput at full in exchange for having no ready combinational path.
- **Ordering:** tokens leave in strict arrival order; none are duplicated or dropped.
- **Protocol assumptions on neighbours:**
  - Upstream holds `ins` and `ins_valid` stable until accepted.
  - The FIFO holds `outs` and `outs_valid` stable while `outs_valid`=1 and `outs_ready`=0.
- **Reset (asynchronous assert, any cycle including mid-transfer):**
  - `hd`=0, `tl`=0, `cnt`=0, so `outs_valid`=0 and `ins_ready`=1 immediately.
  - All stored tokens are discarded.
  - Data array contents are not reset; `outs` is don't-care until the first push.
  - Release is synchronous to `clk` via standard reset deassertion; the first push can be accepted on the first rising edge after `rst` falls.

## Timing
- Latency: 1 cycle. A token pushed at edge N is presented with `outs_valid`=1 after edge N and can be popped at edge N+1.
- Throughput: 1 token per cycle whenever 0 < `cnt` < `NUM_SLOTS`, or when empty and continuously fed.
- Ready at full: `ins_ready` rises the cycle after a pop from full.
- Combinational paths: none from `ins_valid` or `outs_ready` to `ins_ready`, `outs_valid` or `outs`.
- Reset values of outputs:
  - `outs_valid`=0
  - `ins_ready`=1
  - `outs`=X, don't-care

## Test plan
- **Fill/drain:** `NUM_SLOTS`=4, `outs_ready`=0, push 0x11, 0x22, 0x33, 0x44.
  - `ins_ready` falls after the 4th push; a 5th token 0x55 is held off.
  - Then `outs_ready`=1: outputs are 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `outs_valid` falls after the last, and 0x55 is then accepted.
- **Streaming:** `ins_valid`=`outs_ready`=1 for 20 cycles with an incrementing pattern 0..19.
  - Output equals input delayed 1 cycle; `cnt` stays at 1; no bubbles.
- **Wrap, non-power-of-two:** `NUM_SLOTS`=3, 10 pushes and pops with random stalls.
  - Pointers wrap 2 to 0; output order is 0..9.
- **Back-pressure stability:** `outs_ready` toggled randomly with 30% low.
  - While stalled, `outs` and `outs_valid` stay constant.
  - A scoreboard sees every token exactly once, in order.
- **Reset mid-operation:** `cnt`=3, assert `rst` between clock edges.
  - `outs_valid`=0 and `ins_ready`=1 without waiting for a clock edge.
  - After release, a push of 0xA5 emerges as the first output; old tokens never appear.
- **Feeding `andi`:** FIFO drives `lhs`; `rhs_valid` is delayed 3 cycles.
  - `lhs`=0xF0F0 is held in the FIFO; `result`=0xF0F0 & `rhs`=0x0FF0 → 0x00F0 when `rhs` arrives.
  - The FIFO pops exactly once, in the join cycle.

Source files
------------

// File: rtl/operand_fifo.sv
// Elastic circular-buffer FIFO feeding one operand channel of a two-operand unit.
// All outputs come from registered state only, so no input-to-output combinational path exists.
module operand_fifo #(
    parameter int unsigned DATA_TYPE = 32,
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int unsigned PTR_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

    logic [DATA_TYPE-1:0] r_mem [NUM_SLOTS];
    logic [PTR_W-1:0]     r_hd;
    logic [PTR_W-1:0]     r_tl;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_push;
    logic                 w_pop;
    logic [PTR_W-1:0]     w_hd_nxt;
    logic [PTR_W-1:0]     w_tl_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    assign outs_valid = (r_cnt != '0);
    assign ins_ready  = (r_cnt != FULL_CNT);
    assign outs       = r_mem[r_hd];

    assign w_push = ins_valid & ins_ready;
    assign w_pop  = outs_valid & outs_ready;

    // Explicit compare-and-reset wrap keeps non-power-of-two depths correct.
    always_comb begin
        w_hd_nxt  = r_hd;
        w_tl_nxt  = r_tl;
        w_cnt_nxt = r_cnt;
        if (w_push) begin
            w_tl_nxt = (r_tl == LAST_SLOT) ? '0 : r_tl + PTR_W'(1);
        end
        if (w_pop) begin
            w_hd_nxt = (r_hd == LAST_SLOT) ? '0 : r_hd + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hd  <= '0;
            r_tl  <= '0;
            r_cnt <= '0;
        end else begin
            r_hd  <= w_hd_nxt;
            r_tl  <= w_tl_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Data array is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tl] <= ins;
        end
    end

endmodule

// File: tb/tb_operand_fifo.sv
// Scoreboard bench for operand_fifo: a 4-slot instance for most scenarios and a
// 3-slot instance for non-power-of-two wrap, both checked against queue models.
module tb_operand_fifo;

    localparam int unsigned DW  = 32;
    localparam int unsigned NS  = 4;
    localparam int unsigned NS3 = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    logic [DW-1:0] ins3;
    logic          ins_valid3;
    logic          ins_ready3;
    logic [DW-1:0] outs3;
    logic          outs_valid3;
    logic          outs_ready3;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] q  [$];
    logic [DW-1:0] q3 [$];

    int            pop_cnt  = 0;
    logic [DW-1:0] last_pop = '0;
    int            rx3      = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_outs  = '0;
    logic          acc  = 1'b0;
    logic          acc3 = 1'b0;

    always #5 clk = ~clk;

    operand_fifo #(.DATA_TYPE(DW), .NUM_SLOTS(NS)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    operand_fifo #(.DATA_TYPE(DW), .NUM_SLOTS(NS3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins3),
        .ins_valid  (ins_valid3),
        .ins_ready  (ins_ready3),
        .outs       (outs3),
        .outs_valid (outs_valid3),
        .outs_ready (outs_ready3)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 4-slot FIFO: flags, stall stability and in-order delivery.
    always @(negedge clk) begin
        if (!rst) begin
            chk("outs_valid", {31'd0, outs_valid}, {31'd0, q.size() != 0});
            chk("ins_ready", {31'd0, ins_ready}, {31'd0, q.size() != NS});
            if (stall_prev) begin
                chk("stall_valid", {31'd0, outs_valid}, 32'd1);
                chk("stall_outs", outs, prev_outs);
            end
            if (outs_valid && outs_ready) begin
                if (q.size() == 0) begin
                    chk("pop_on_empty", 32'd1, 32'd0);
                end else begin
                    chk("outs", outs, q.pop_front());
                end
                last_pop = outs;
                pop_cnt++;
            end
            stall_prev = outs_valid && !outs_ready;
            prev_outs  = outs;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Monitor for the 3-slot FIFO: tokens must come out as 0,1,2,... in order.
    always @(negedge clk) begin
        if (!rst) begin
            chk("outs_valid3", {31'd0, outs_valid3}, {31'd0, q3.size() != 0});
            chk("ins_ready3", {31'd0, ins_ready3}, {31'd0, q3.size() != NS3});
            if (outs_valid3 && outs_ready3) begin
                if (q3.size() == 0) begin
                    chk("pop_on_empty3", 32'd1, 32'd0);
                end else begin
                    chk("outs3_model", outs3, q3.pop_front());
                end
                chk("outs3_order", outs3, DW'(rx3));
                rx3++;
            end
        end
    end

    // One clock: record accepted tokens into the scoreboards after the monitors run.
    task automatic step();
        @(negedge clk);
        #1;
        acc  = ins_valid && ins_ready;
        acc3 = ins_valid3 && ins_ready3;
        if (acc)  q.push_back(ins);
        if (acc3) q3.push_back(ins3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int tok;
        logic rhs_valid;
        logic [DW-1:0] rhs;
        logic [DW-1:0] result;
        logic [DW-1:0] fill_vals [4];

        rst = 1'b1;
        ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        ins3 = '0; ins_valid3 = 1'b0; outs_ready3 = 1'b0;
        rhs_valid = 1'b0; rhs = 32'h0FF0;
        #12;
        chk("rst_outs_valid", {31'd0, outs_valid}, 32'd0);
        chk("rst_ins_ready", {31'd0, ins_ready}, 32'd1);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Fill/drain
        fill_vals[0] = 32'h11; fill_vals[1] = 32'h22;
        fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            ins = fill_vals[i]; ins_valid = 1'b1;
            step();
        end
        chk("full_ins_ready", {31'd0, ins_ready}, 32'd0);
        ins = 32'h55;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("held_off_55", {31'd0, acc}, 32'd0);
        end
        ins_valid = 1'b0; outs_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) step();
        chk("drain_pops", DW'(pop_cnt - p0), 32'd4);
        chk("drain_valid", {31'd0, outs_valid}, 32'd0);
        ins_valid = 1'b1;
        step();
        chk("accept_55", {31'd0, acc}, 32'd1);
        ins_valid = 1'b0;
        step();
        chk("pop_55", last_pop, 32'h55);

        // Streaming
        p0 = pop_cnt;
        outs_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) chk("stream_delay", outs, DW'(i - 1));
            ins = DW'(i); ins_valid = 1'b1;
            step();
        end
        chk("stream_pops", DW'(pop_cnt - p0), 32'd19);
        chk("stream_cnt", DW'(q.size()), 32'd1);
        ins_valid = 1'b0;
        step();

        // Non-power-of-two wrap on the 3-slot instance
        tok = 0;
        for (int c = 0; c < 400 && rx3 < 10; c++) begin
            if (acc3) begin
                tok++;
                ins_valid3 = 1'b0;
            end
            if (!ins_valid3 && tok < 10 && $urandom_range(0, 2) != 0) begin
                ins3 = DW'(tok); ins_valid3 = 1'b1;
            end
            outs_ready3 = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("wrap_count", DW'(rx3), 32'd10);
        ins_valid3 = 1'b0; outs_ready3 = 1'b0;

        // Random back-pressure with 30% stalls
        acc = 1'b0;
        ins_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (acc) ins_valid = 1'b0;
            if (!ins_valid && $urandom_range(0, 9) < 7) begin
                ins = $urandom; ins_valid = 1'b1;
            end
            outs_ready = ($urandom_range(0, 9) >= 3);
            step();
        end
        ins_valid = 1'b0; outs_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) step();
        chk("random_drained", DW'(q.size()), 32'd0);

        // Reset mid-operation with three tokens stored
        outs_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ins = 32'hC0 + DW'(i); ins_valid = 1'b1;
            step();
        end
        ins_valid = 1'b0;
        chk("pre_rst_cnt", DW'(q.size()), 32'd3);
        #2 rst = 1'b1;
        q.delete();
        q3.delete();
        #1;
        chk("async_outs_valid", {31'd0, outs_valid}, 32'd0);
        chk("async_ins_ready", {31'd0, ins_ready}, 32'd1);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        p0 = pop_cnt;
        ins = 32'hA5; ins_valid = 1'b1; outs_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        step();
        chk("post_rst_first", last_pop, 32'hA5);
        chk("post_rst_pops", DW'(pop_cnt - p0), 32'd1);
        step();
        chk("post_rst_stale", DW'(pop_cnt - p0), 32'd1);

        // Feeding an AND unit: lhs waits in the FIFO for rhs arriving 3 cycles later
        outs_ready = 1'b0;
        ins = 32'hF0F0; ins_valid = 1'b1;
        step();
        ins_valid = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 3; i++) begin
            outs_ready = rhs_valid;
            step();
        end
        chk("andi_hold", DW'(pop_cnt - p0), 32'd0);
        rhs_valid = 1'b1;
        outs_ready = rhs_valid;
        result = outs & rhs;
        chk("andi_join_valid", {31'd0, outs_valid}, 32'd1);
        chk("andi_result", result, 32'h00F0);
        step();
        rhs_valid = 1'b0;
        outs_ready = rhs_valid;
        step();
        chk("andi_single_pop", DW'(pop_cnt - p0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
